// File: rtl/icc_mailbox_hub_pkg.sv
// Shared defaults, width helpers and FIFO operation codes for the inter-core mailbox hub.
package icc_mailbox_hub_pkg;

  localparam int DEF_NUM_CORES = 32'sd4;
  localparam int DEF_DATA_W    = 32'sd14;
  localparam int DEF_DEPTH     = 32'sd4;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic int id_width(input int n);
    return (n > 32'sd2) ? $clog2(n) : 32'sd1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

endpackage

// File: rtl/icc_mailbox_hub_if.sv
// Flattened per-core send/receive bundle between the cores and the mailbox hub.
interface icc_mailbox_hub_if #(
  parameter  int NUM_CORES = icc_mailbox_hub_pkg::DEF_NUM_CORES,
  parameter  int DATA_W    = icc_mailbox_hub_pkg::DEF_DATA_W,
  parameter  int DEPTH     = icc_mailbox_hub_pkg::DEF_DEPTH,
  localparam int ID_W      = icc_mailbox_hub_pkg::id_width(NUM_CORES),
  localparam int CNT_W     = icc_mailbox_hub_pkg::cnt_width(DEPTH)
);

  logic [NUM_CORES-1:0]        tx_valid;
  logic [NUM_CORES*ID_W-1:0]   tx_dest;
  logic [NUM_CORES*DATA_W-1:0] tx_data;
  logic [NUM_CORES-1:0]        tx_ready;
  logic [NUM_CORES-1:0]        rx_valid;
  logic [NUM_CORES*DATA_W-1:0] rx_data;
  logic [NUM_CORES*ID_W-1:0]   rx_src;
  logic [NUM_CORES-1:0]        rx_pop;
  logic [NUM_CORES*CNT_W-1:0]  rx_count;
  logic [NUM_CORES-1:0]        err_dest;
  logic [NUM_CORES-1:0]        err_clr;

  modport master (
    output tx_valid, tx_dest, tx_data, rx_pop, err_clr,
    input  tx_ready, rx_valid, rx_data, rx_src, rx_count, err_dest
  );

  modport slave (
    input  tx_valid, tx_dest, tx_data, rx_pop, err_clr,
    output tx_ready, rx_valid, rx_data, rx_src, rx_count, err_dest
  );

endinterface

// File: rtl/icc_mailbox_hub_rx_fifo.sv
// Show-ahead receive FIFO holding {src id, data} entries for one destination core.
module icc_rx_fifo
  import icc_mailbox_hub_pkg::*;
#(
  parameter  int W     = 32'sd16,
  parameter  int DEPTH = 32'sd4,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  fifo_op_e         op_s;

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == '0);
  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

  // A full FIFO refuses the push and an empty one ignores the pop, even if the other side is active.
  always_comb begin
    op_s = fifo_op_e'({push && !full, pop && !empty});
  end

  // Storage, head/tail pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 32'sd0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      case (op_s)
        FIFO_PUSH: begin
          mem_r[wr_ptr_r] <= wdata;
          wr_ptr_r        <= wr_ptr_r + AW'(32'd1);
          count_r         <= count_r + CNT_W'(32'd1);
        end
        FIFO_POP: begin
          rd_ptr_r <= rd_ptr_r + AW'(32'd1);
          count_r  <= count_r - CNT_W'(32'd1);
        end
        FIFO_BOTH: begin
          mem_r[wr_ptr_r] <= wdata;
          wr_ptr_r        <= wr_ptr_r + AW'(32'd1);
          rd_ptr_r        <= rd_ptr_r + AW'(32'd1);
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/icc_mailbox_hub.sv
// Inter-core mailbox hub: per-destination round-robin arbitration into show-ahead receive FIFOs.
module icc_mailbox_hub
  import icc_mailbox_hub_pkg::*;
#(
  parameter  int NUM_CORES = DEF_NUM_CORES,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int DEPTH     = DEF_DEPTH,
  localparam int ID_W      = id_width(NUM_CORES),
  localparam int CNT_W     = cnt_width(DEPTH)
) (
  input logic              Clock_pin,
  input logic              Resetn_pin,
  icc_mailbox_hub_if.slave bus
);

  localparam int ENT_W = ID_W + DATA_W;

  logic [NUM_CORES-1:0] grant_s     [NUM_CORES];
  logic [ID_W-1:0]      ptr_r       [NUM_CORES];
  logic [ID_W-1:0]      ptr_nxt_s   [NUM_CORES];
  logic [ENT_W-1:0]     push_word_s [NUM_CORES];
  logic [ENT_W-1:0]     head_s      [NUM_CORES];
  logic [CNT_W-1:0]     count_s     [NUM_CORES];
  logic [NUM_CORES-1:0] bad_dest_s;
  logic [NUM_CORES-1:0] push_s;
  logic [NUM_CORES-1:0] full_s;
  logic [NUM_CORES-1:0] empty_s;
  logic [NUM_CORES-1:0] ready_s;
  logic [NUM_CORES-1:0] err_r;

  // Per-destination arbitration: first requester at or after ptr wins unless the FIFO started full.
  always_comb begin : arb
    logic found_s;
    int   idx_s;
    found_s = 1'b0;
    idx_s   = 32'sd0;
    for (int i = 32'sd0; i < NUM_CORES; i++) begin
      bad_dest_s[i] = bus.tx_valid[i] && (int'(bus.tx_dest[i*ID_W +: ID_W]) >= NUM_CORES);
    end
    for (int d = 32'sd0; d < NUM_CORES; d++) begin
      grant_s[d]     = '0;
      ptr_nxt_s[d]   = ptr_r[d];
      push_word_s[d] = '0;
      found_s        = 1'b0;
      if (!full_s[d]) begin
        for (int k = 32'sd0; k < NUM_CORES; k++) begin
          idx_s = (int'(ptr_r[d]) + k) % NUM_CORES;
          if (!found_s && bus.tx_valid[idx_s] &&
              (int'(bus.tx_dest[idx_s*ID_W +: ID_W]) == d)) begin
            found_s             = 1'b1;
            grant_s[d][idx_s]   = 1'b1;
            ptr_nxt_s[d]        = ID_W'((idx_s + 32'sd1) % NUM_CORES);
            push_word_s[d]      = {ID_W'(idx_s), bus.tx_data[idx_s*DATA_W +: DATA_W]};
          end else begin
            found_s = found_s;
          end
        end
      end else begin
        found_s = 1'b0;
      end
    end
  end

  // Senders are acknowledged when they win a destination or aim at a core that does not exist.
  always_comb begin
    ready_s = bad_dest_s;
    for (int d = 32'sd0; d < NUM_CORES; d++) begin
      ready_s = ready_s | grant_s[d];
    end
    bus.tx_ready = ready_s;
  end

  // Round-robin pointers move just past each winner.
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      for (int d = 32'sd0; d < NUM_CORES; d++) begin
        ptr_r[d] <= '0;
      end
    end else begin
      for (int d = 32'sd0; d < NUM_CORES; d++) begin
        ptr_r[d] <= ptr_nxt_s[d];
      end
    end
  end

  // Sticky bad-destination flags; a fresh set beats a same-cycle clear.
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      err_r <= '0;
    end else begin
      err_r <= bad_dest_s | (err_r & ~bus.err_clr);
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_rx
    assign push_s[g] = |grant_s[g];

    icc_rx_fifo #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (Clock_pin),
      .rst_n (Resetn_pin),
      .push  (push_s[g]),
      .pop   (bus.rx_pop[g]),
      .wdata (push_word_s[g]),
      .rdata (head_s[g]),
      .full  (full_s[g]),
      .empty (empty_s[g]),
      .count (count_s[g])
    );
  end

  // Flatten FIFO heads and status onto the receive buses.
  always_comb begin
    bus.rx_valid = '0;
    bus.rx_data  = '0;
    bus.rx_src   = '0;
    bus.rx_count = '0;
    for (int i = 32'sd0; i < NUM_CORES; i++) begin
      bus.rx_valid[i]                   = !empty_s[i];
      bus.rx_data[i*DATA_W +: DATA_W]   = head_s[i][DATA_W-1:0];
      bus.rx_src[i*ID_W +: ID_W]        = head_s[i][ENT_W-1 -: ID_W];
      bus.rx_count[i*CNT_W +: CNT_W]    = count_s[i];
    end
    bus.err_dest = err_r;
  end

endmodule

// File: tb/tb_icc_mailbox_hub.sv
// Directed, table-driven bench for icc_mailbox_hub (4-core main config plus a 5-core config for bad ids).
module tb_icc_mailbox_hub;

  localparam int N  = 4;
  localparam int DW = 14;
  localparam int DP = 4;
  localparam int N5 = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  icc_mailbox_hub_if #(.NUM_CORES(N),  .DATA_W(DW), .DEPTH(DP)) bus4 ();
  icc_mailbox_hub_if #(.NUM_CORES(N5), .DATA_W(DW), .DEPTH(DP)) bus5 ();

  icc_mailbox_hub #(.NUM_CORES(N),  .DATA_W(DW), .DEPTH(DP)) dut4 (
    .Clock_pin(clk), .Resetn_pin(rst_n), .bus(bus4));
  icc_mailbox_hub #(.NUM_CORES(N5), .DATA_W(DW), .DEPTH(DP)) dut5 (
    .Clock_pin(clk), .Resetn_pin(rst_n), .bus(bus5));

  typedef struct {
    bit          rst;
    logic [3:0]  valid;
    logic [7:0]  dest;
    logic [55:0] data;
    logic [3:0]  pop;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_rv;
    logic [11:0] exp_cnt;
    logic [55:0] exp_data;
    logic [7:0]  exp_src;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [55:0] w4(input logic [13:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction
  function automatic logic [7:0] s4(input logic [1:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction
  function automatic logic [11:0] c4(input logic [2:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic add(input bit rst, input logic [3:0] valid, input logic [7:0] dest,
                     input logic [55:0] data, input logic [3:0] pop, input logic [3:0] er,
                     input logic [3:0] erv, input logic [11:0] ecnt, input logic [55:0] edata,
                     input logic [7:0] esrc);
    vec_t v;
    v.rst = rst; v.valid = valid; v.dest = dest; v.data = data; v.pop = pop;
    v.exp_ready = er; v.exp_rv = erv; v.exp_cnt = ecnt; v.exp_data = edata; v.exp_src = esrc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus4.tx_valid = '0; bus4.tx_dest = '0; bus4.tx_data = '0; bus4.rx_pop = '0; bus4.err_clr = '0;
    bus5.tx_valid = '0; bus5.tx_dest = '0; bus5.tx_data = '0; bus5.rx_pop = '0; bus5.err_clr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();

    // vectors: inputs applied for one cycle; expectations are tx_ready that cycle
    // and the registered receive state seen at the start of that cycle
    add(1, 4'b0000, 8'h00, '0, 4'b0000, 4'b0000, 4'b0000, 12'h000, '0, '0);
    add(0, 4'b0010, s4(0,0,0,0), w4(0,0,14'h1ABC,0), 4'b0000, 4'b0010, 4'b0000, 12'h000, '0, '0);
    add(0, 4'b0000, 8'h00, '0, 4'b0001, 4'b0000, 4'b0001, c4(0,0,0,1), w4(0,0,0,14'h1ABC), s4(0,0,0,1));
    add(0, 4'b0000, 8'h00, '0, 4'b0000, 4'b0000, 4'b0000, 12'h000, '0, '0);
    // contention on destination 0, then full, then full with a simultaneous pop
    add(1, 4'b1110, 8'h00, w4(14'h0333,14'h0222,14'h0111,0), 4'b0000, 4'b0010, 4'b0000, 12'h000, '0, '0);
    add(0, 4'b1110, 8'h00, w4(14'h0333,14'h0222,14'h0444,0), 4'b0000, 4'b0100, 4'b0001, c4(0,0,0,1), w4(0,0,0,14'h0111), s4(0,0,0,1));
    add(0, 4'b1110, 8'h00, w4(14'h0333,14'h0555,14'h0444,0), 4'b0000, 4'b1000, 4'b0001, c4(0,0,0,2), w4(0,0,0,14'h0111), s4(0,0,0,1));
    add(0, 4'b1110, 8'h00, w4(14'h0666,14'h0555,14'h0444,0), 4'b0000, 4'b0010, 4'b0001, c4(0,0,0,3), w4(0,0,0,14'h0111), s4(0,0,0,1));
    add(0, 4'b1110, 8'h00, w4(14'h0666,14'h0555,14'h0777,0), 4'b0000, 4'b0000, 4'b0001, c4(0,0,0,4), w4(0,0,0,14'h0111), s4(0,0,0,1));
    add(0, 4'b0100, 8'h00, w4(0,14'h0555,0,0), 4'b0001, 4'b0000, 4'b0001, c4(0,0,0,4), w4(0,0,0,14'h0111), s4(0,0,0,1));
    add(0, 4'b0100, 8'h00, w4(0,14'h0555,0,0), 4'b0000, 4'b0100, 4'b0001, c4(0,0,0,3), w4(0,0,0,14'h0222), s4(0,0,0,2));
    add(0, 4'b0000, 8'h00, '0, 4'b0000, 4'b0000, 4'b0001, c4(0,0,0,4), w4(0,0,0,14'h0222), s4(0,0,0,2));
    // parallel + loopback, pop on empty, push/pop on empty and on non-empty FIFO
    add(1, 4'b1001, s4(1,0,0,0), w4(14'h3FFF,0,0,14'h0005), 4'b0000, 4'b1001, 4'b0000, 12'h000, '0, '0);
    add(0, 4'b0000, 8'h00, '0, 4'b0000, 4'b0000, 4'b0011, c4(0,0,1,1), w4(0,0,14'h3FFF,14'h0005), s4(0,0,3,0));
    add(0, 4'b0000, 8'h00, '0, 4'b1111, 4'b0000, 4'b0011, c4(0,0,1,1), w4(0,0,14'h3FFF,14'h0005), s4(0,0,3,0));
    add(0, 4'b0100, s4(0,2,0,0), w4(0,14'h1234,0,0), 4'b0100, 4'b0100, 4'b0000, 12'h000, '0, '0);
    add(0, 4'b0000, 8'h00, '0, 4'b0000, 4'b0000, 4'b0100, c4(0,1,0,0), w4(0,14'h1234,0,0), s4(0,2,0,0));
    add(0, 4'b0010, s4(0,0,2,0), w4(0,0,14'h0042,0), 4'b0100, 4'b0010, 4'b0100, c4(0,1,0,0), w4(0,14'h1234,0,0), s4(0,2,0,0));
    add(0, 4'b0000, 8'h00, '0, 4'b0000, 4'b0000, 4'b0100, c4(0,1,0,0), w4(0,14'h0042,0,0), s4(0,1,0,0));

    do_reset();
    chk("reset rx_data", bus4.rx_data, '0);
    chk("reset rx_src", bus4.rx_src, '0);

    for (int n = 0; n < vecs.size(); n++) begin
      if (vecs[n].rst) do_reset();
      bus4.tx_valid = vecs[n].valid;
      bus4.tx_dest  = vecs[n].dest;
      bus4.tx_data  = vecs[n].data;
      bus4.rx_pop   = vecs[n].pop;
      #1;
      chk($sformatf("v%0d tx_ready", n), bus4.tx_ready, vecs[n].exp_ready);
      chk($sformatf("v%0d rx_valid", n), bus4.rx_valid, vecs[n].exp_rv);
      chk($sformatf("v%0d rx_count", n), bus4.rx_count, vecs[n].exp_cnt);
      chk($sformatf("v%0d err_dest", n), bus4.err_dest, 4'b0000);
      for (int l = 0; l < N; l++) begin
        if (vecs[n].exp_rv[l]) begin
          chk($sformatf("v%0d rx_data%0d", n, l), bus4.rx_data[l*14 +: 14], vecs[n].exp_data[l*14 +: 14]);
          chk($sformatf("v%0d rx_src%0d", n, l), bus4.rx_src[l*2 +: 2], vecs[n].exp_src[l*2 +: 2]);
        end
      end
      step();
    end
    idle_inputs();

    // 5-core configuration: 3-bit ids, so ids 5..7 do not exist
    do_reset();
    chk("n5 reset err", bus5.err_dest, 5'b00000);
    bus5.tx_valid = 5'b00001; bus5.tx_dest[2:0] = 3'd7; bus5.tx_data[13:0] = 14'h0ABC;
    #1;
    chk("n5 bad ready", bus5.tx_ready, 5'b00001);
    step();
    idle_inputs();
    #1;
    chk("n5 err set", bus5.err_dest, 5'b00001);
    chk("n5 dropped", bus5.rx_valid, 5'b00000);
    bus5.err_clr = 5'b00001;
    step();
    idle_inputs();
    #1;
    chk("n5 err clr", bus5.err_dest, 5'b00000);
    bus5.tx_valid = 5'b00011; bus5.tx_dest[2:0] = 3'd7; bus5.tx_dest[5:3] = 3'd5;
    bus5.err_clr = 5'b00001;
    #1;
    chk("n5 bad ready2", bus5.tx_ready, 5'b00011);
    step();
    idle_inputs();
    #1;
    chk("n5 set beats clr", bus5.err_dest, 5'b00011);
    step();
    chk("n5 err sticky", bus5.err_dest, 5'b00011);
    bus5.tx_valid = 5'b10000; bus5.tx_dest[14:12] = 3'd4; bus5.tx_data[69:56] = 14'h0055;
    #1;
    chk("n5 core4 ready", bus5.tx_ready, 5'b10000);
    step();
    idle_inputs();
    #1;
    chk("n5 rx_valid", bus5.rx_valid, 5'b10000);
    chk("n5 rx_data4", bus5.rx_data[69:56], 14'h0055);
    chk("n5 rx_src4", bus5.rx_src[14:12], 3'd4);
    chk("n5 rx_count4", bus5.rx_count[14:12], 3'd1);
    chk("n4 err untouched", bus4.err_dest, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icc_mailbox_hub.md
Name: icc_mailbox_hub

Overview:
- Hardware inter-core message hub for the multicore processor top level.
- Replaces point-to-point ack/data port pairs with per-destination receive FIFOs and a hardware valid/ready handshake.
- Parametrised in core count, word width and FIFO depth.
- Each core sends a DATA_W word to any destination core, including itself. Contending senders to one destination are served round-robin.

Parameters:
- NUM_CORES, 4, number of attached cores (2..16).
- DATA_W, 14, message word width; matches the core peripheral port width.
- DEPTH, 4, receive FIFO entries per destination (power of 2, >=2).
- ID_W, derived clog2(NUM_CORES) with minimum 1, core id width. Localparam, not overridable.
- CNT_W, derived clog2(DEPTH+1), occupancy count width. Localparam.

Ports:
- Clock_pin  in  1  single clock; all state updates on rising edge.
- Resetn_pin  in  1  asynchronous, active-low reset.
- tx_valid  in  NUM_CORES  sender i requests a transfer.
- tx_dest  in  NUM_CORES*ID_W  destination id for sender i (slice i).
- tx_data  in  NUM_CORES*DATA_W  message word for sender i.
- tx_ready  out  NUM_CORES  transfer from sender i accepted this cycle.
- rx_valid  out  NUM_CORES  FIFO for core i is non-empty.
- rx_data  out  NUM_CORES*DATA_W  head word of FIFO i (show-ahead).
- rx_src  out  NUM_CORES*ID_W  sender id of the head word.
- rx_pop  in  NUM_CORES  core i consumes its head word.
- rx_count  out  NUM_CORES*CNT_W  occupancy of FIFO i.
- err_dest  out  NUM_CORES  sticky flag: sender i targeted a nonexistent core.
- err_clr  in  NUM_CORES  clears err_dest[i].

Behaviour:
- Reset (async assert, sync release) clears:
  - all FIFOs: rx_valid=0, rx_count=0, rx_data=0, rx_src=0;
  - err_dest=0;
  - all round-robin pointers to 0 (core 0 has highest priority first).
- tx_ready is combinational from tx_valid, tx_dest, FIFO full flags and arbiter pointers.
- A transfer occurs when tx_valid[i] and tx_ready[i] are both high on a rising edge. Sender holds tx_data/tx_dest stable until accepted.
- Arbitration, per destination d:
  - requesters are senders with tx_valid=1 and tx_dest=d;
  - if FIFO d is full at cycle start, no grant;
  - otherwise the first requester at or after ptr[d], cyclically, wins and gets tx_ready=1;
  - after a grant, ptr[d] = winner+1 mod NUM_CORES; it is unchanged otherwise.
- At most one push per FIFO per cycle. Different destinations are granted in parallel in the same cycle.
- Push: {src id, data} is written at the tail. rx_valid/rx_count reflect it on the next cycle (1-cycle latency).
- Pop: rx_pop[i] with rx_valid[i]=1 advances the head. Pop on empty is ignored, with no state change.
- Push and pop to the same FIFO in one cycle:
  - count unchanged, both take effect;
  - if the FIFO is full at cycle start, the push is still refused (no same-cycle bypass);
  - if empty, the pushed word appears next cycle and the pop is ignored.
- Pointers wrap modulo DEPTH. Full means count==DEPTH; empty means count==0.
- Invalid destination (tx_dest >= NUM_CORES while tx_valid=1):
  - tx_ready=1 that cycle and the word is discarded;
  - err_dest[i] is set the next cycle;
  - if err_clr and a set event occur in the same cycle, set wins.
- Reset mid-operation: in-flight words are lost and handshakes are abandoned. Senders must re-present after reset.

Decomposition:
- Shared header icc_defs.vh holds:
  - id-width and count-width computation macros;
  - slice macros for the flattened buses;
  - the default NUM_CORES/DATA_W/DEPTH constants used by the multicore top.
- One natural sub-module: icc_rx_fifo. It is a single show-ahead FIFO of {ID_W+DATA_W} bits with push/pop/full/empty/count, instantiated NUM_CORES times in a generate loop.
- Arbiters stay inline in a generate loop.

Test Plan:
- Reset state: after reset, all rx_valid=0, rx_count=0, err_dest=0, tx_ready=0 with tx_valid=0.
- Basic transfer: core1 sends 14'h1ABC to dest 0 → tx_ready[1]=1 that cycle. Next cycle rx_valid[0]=1, rx_data[0]=14'h1ABC, rx_src[0]=1, rx_count[0]=1. After rx_pop[0], rx_valid[0]=0.
- Contention: cores 1, 2 and 3 all send to dest 0 continuously for 3 cycles, no pops.
  - Grants go 1, 2, 3 in order.
  - A fourth request from core 1 is then granted, filling FIFO 0 (count=4).
  - A further request gets tx_ready=0.
- Full with simultaneous pop: FIFO 0 full, core 2 requests and rx_pop[0]=1 in the same cycle.
  - Push refused, count becomes 3.
  - Next cycle core 2 is granted and count returns to 4.
- Parallel and loopback: core0→core0 (14'h0005) and core3→core1 (14'h3FFF) in the same cycle. Both are granted; next cycle both FIFOs hold one word with correct src.
- Invalid dest and errors: NUM_CORES=4 with tx_dest width forced to 3 bits (NUM_CORES=5 configuration), dest=7.
  - Word is accepted and dropped; err_dest sets.
  - err_clr clears it.
  - Simultaneous err_clr with a new invalid send leaves err_dest=1.
